my_div_seq_32bit: RTL and testbench

MY_DIV_SEQ_32BIT -- requirements
Module: my_div_seq_32bit

---
 rtl/my_alu_pkg.sv | 22 ++
 rtl/my_sub_33bit.sv | 19 +
 rtl/my_div_seq_32bit.sv | 136 +++++++++++++
 tb/tb_my_div_seq_32bit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_alu_pkg.sv
// ============================================================================
// Module   : my_alu_pkg
// Purpose  : Shared constants and FSM state type for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package my_alu_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/my_sub_33bit.sv
// ============================================================================
// Module   : my_sub_33bit
// Purpose  : 33-bit trial subtractor returning difference and borrow out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module my_sub_33bit (
    input  logic [32:0] minuend,
    input  logic [32:0] subtrahend,
    output logic [32:0] diff,
    output logic        borrow
);

    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

`default_nettype wire

// File: rtl/my_div_seq_32bit.sv
// ============================================================================
// Module   : my_div_seq_32bit
// Purpose  : Sequential restoring divider, one quotient bit per cycle.
//            Define MY_DIV_SIGNED_EN for two's-complement operation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module my_div_seq_32bit #(
    parameter int WIDTH = my_alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import my_alu_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITERATIONS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_keep;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;

    // The dividend register doubles as the quotient accumulator.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};

    my_sub_33bit u_sub (
        .minuend    (w_shift),
        .subtrahend ({1'b0, r_dvs}),
        .diff       (w_diff),
        .borrow     (w_borrow)
    );

    assign w_keep     = ~w_borrow & ~w_diff[WIDTH];
    assign w_rem_next = w_keep ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_keep};

`ifdef MY_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag     = a[WIDTH-1] ? -a : a;
    assign w_b_mag     = b[WIDTH-1] ? -b : b;
    assign w_quo_final = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem_final = r_neg_r ? -w_rem_next : w_rem_next;
`else
    assign w_a_mag     = a;
    assign w_b_mag     = b;
    assign w_quo_final = w_quo_next;
    assign w_rem_final = w_rem_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef MY_DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            r_state     <= S_DONE;
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_dvd       <= w_a_mag;
                            r_dvs       <= w_b_mag;
                            r_rem       <= '0;
                            r_count     <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
`ifdef MY_DIV_SIGNED_EN
                            r_neg_q     <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_r     <= a[WIDTH-1];
`endif
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == C_LAST) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= w_quo_final;
                        remainder <= w_rem_final;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_my_div_seq_32bit.sv
// ============================================================================
// Module   : tb_my_div_seq_32bit
// Purpose  : Directed self-checking bench for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_my_div_seq_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    my_div_seq_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one start and waits (bounded) for done; lat counts cycles after the accepting edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int bcyc, output bit seen);
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcyc = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; a = 32'd5; b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b q=%h r=%h dbz=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat; int bcyc; bit seen;
        do_op(32'd100, 32'd7, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 33) begin
            n_fail++;
            $display("FAIL basic_latency: seen=%0d lat=%0d, required done at 33", seen, lat);
        end
        n_checks++;
        if (bcyc != 32) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: %0d, required 32", bcyc);
        end
        n_checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || quotient !== 32'd14) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: done=%b q=%0d, required done=0 q=14", done, quotient);
        end
    endtask

    task automatic test_div_by_zero();
        int lat; int bcyc; bit seen;
        do_op(32'd55, 32'd0, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 1 || bcyc != 0) begin
            n_fail++;
            $display("FAIL dbz_latency: seen=%0d lat=%0d busy_cycles=%0d, required 1/1/0",
                     seen, lat, bcyc);
        end
        n_checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd55 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ffffffff r=55 dbz=1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_msb_divisor();
        int lat; int bcyc; bit seen;
        do_op(32'hFFFF_FFFF, 32'h8000_0000, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 33) begin
            n_fail++;
            $display("FAIL msb_latency: seen=%0d lat=%0d, required done at 33", seen, lat);
        end
        n_checks++;
        if (quotient !== 32'd1 || remainder !== 32'h7FFF_FFFF || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_result: q=%h r=%h dbz=%b, required q=1 r=7fffffff dbz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; int bcyc; bit seen;
        bit stray_done;
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b q=%h r=%h dbz=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        stray_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) stray_done = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (stray_done) begin
            n_fail++;
            $display("FAIL midrun_discard: activity=1 after reset, required 0");
        end
        do_op(32'd9, 32'd3, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 33 || quotient !== 32'd3 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_restart: seen=%0d lat=%0d q=%0d r=%0d, required 33 q=3 r=0",
                     seen, lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int cycle;
        int last_done;
        int pulses;
        bit bad_gap;
        bit bad_res;
        @(posedge clk); #1;
        a = 32'd20; b = 32'd6; start = 1'b1;
        cycle = 0; last_done = -1; pulses = 0; bad_gap = 1'b0; bad_res = 1'b0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1;
            cycle++;
            if (done) begin
                pulses++;
                if (quotient !== 32'd3 || remainder !== 32'd2) bad_res = 1'b1;
                if (last_done >= 0 && (cycle - last_done) != 34) bad_gap = 1'b1;
                last_done = cycle;
            end
            if (busy) begin
                a = 32'd12345; b = 32'd1;
            end else begin
                a = 32'd20; b = 32'd6;
            end
        end
        start = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: %0d, required 3", pulses);
        end
        n_checks++;
        if (bad_gap) begin
            n_fail++;
            $display("FAIL b2b_period: spacing not 34 cycles (last at %0d), required 34", last_done);
        end
        n_checks++;
        if (bad_res) begin
            n_fail++;
            $display("FAIL b2b_result: q=%0d r=%0d, required q=3 r=2", quotient, remainder);
        end
        repeat (40) @(posedge clk);
    endtask

`ifdef MY_DIV_SIGNED_EN
    task automatic test_signed();
        int lat; int bcyc; bit seen;
        do_op(-32'sd7, 32'd2, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL signed_neg7_2: lat=%0d q=%h r=%h, required 33 q=fffffffd r=ffffffff",
                     lat, quotient, remainder);
        end
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, seen);
        n_checks++;
        if (!seen || lat != 33 || quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL signed_min_neg1: lat=%0d q=%h r=%h, required 33 q=80000000 r=0",
                     lat, quotient, remainder);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_msb_divisor();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MY_DIV_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
